// File: rtl/free_list_ckpt_pkg.sv
// Shared definitions for the checkpointed physical-register free list.
package free_list_ckpt_pkg;

    localparam int FL_N_WAY      = 2;
    localparam int FL_DEPTH      = 32;
    localparam int FL_PREG_W     = 6;
    localparam int FL_N_CKPT     = 4;
    localparam int FL_FIRST_FREE = 32;
    localparam int FL_PTR_W      = $clog2(FL_DEPTH) + 1;

    // One branch checkpoint: a saved head pointer and its live flag.
    typedef struct packed {
        logic                valid;
        logic [FL_PTR_W-1:0] ptr;
    } fl_ckpt_t;

    // Forward distance from b to a on the wrap-bit pointer circle.
    function automatic logic [FL_PTR_W-1:0] ring_dist(input logic [FL_PTR_W-1:0] a,
                                                      input logic [FL_PTR_W-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/free_list_ckpt_retire_compact.sv
// Packs the retire slots that carry a real told tag (non-zero) into a dense
// list in slot order and reports how many there are.
module free_list_ckpt_retire_compact #(
    parameter int N_WAY  = 2,
    parameter int PREG_W = 6
) (
    input  logic [N_WAY-1:0]             valid,
    input  logic [N_WAY-1:0][PREG_W-1:0] told,
    output logic [N_WAY-1:0][PREG_W-1:0] tags,
    output logic [$clog2(N_WAY):0]       count
);
    localparam int CNT_W = $clog2(N_WAY) + 1;

    logic [N_WAY-1:0] keep;
    logic [CNT_W-1:0] pos [N_WAY];

    genvar gi;
    generate
        for (gi = 0; gi < N_WAY; gi++) begin : g_keep
            assign keep[gi] = valid[gi] && (told[gi] != '0);
        end
    endgenerate

    // Output position of each slot = number of kept slots before it.
    always_comb begin
        for (int i = 0; i < N_WAY; i++) pos[i] = '0;
        for (int i = 1; i < N_WAY; i++) pos[i] = pos[i-1] + CNT_W'(keep[i-1]);
    end

    assign count = pos[N_WAY-1] + CNT_W'(keep[N_WAY-1]);

    // Route each kept tag to its packed position.
    always_comb begin
        tags = '0;
        for (int i = 0; i < N_WAY; i++)
            for (int j = 0; j < N_WAY; j++)
                if (keep[i] && pos[i] == CNT_W'(j)) tags[j] = told[i];
    end

endmodule

// File: rtl/free_list_ckpt.sv
// Circular physical-register free list with per-branch head checkpoints.
// Free tags live in ring slots [head, tail); allocation pops at head, retire
// pushes reclaimed told tags at tail, and recovery simply rewinds head.
module free_list_ckpt
    import free_list_ckpt_pkg::*;
#(
    parameter int N_WAY      = FL_N_WAY,
    parameter int DEPTH      = FL_DEPTH,
    parameter int PREG_W     = FL_PREG_W,
    parameter int N_CKPT     = FL_N_CKPT,
    parameter int FIRST_FREE = FL_FIRST_FREE
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(N_WAY):0]       alloc_num,
    output logic [N_WAY-1:0][PREG_W-1:0] alloc_tag,
    output logic [N_WAY-1:0]             alloc_grant,
    output logic [$clog2(DEPTH):0]       free_num,
    input  logic [N_WAY-1:0]             retire_valid,
    input  logic [N_WAY-1:0][PREG_W-1:0] retire_told,
    input  logic                         ckpt_take,
    input  logic [$clog2(N_WAY):0]       ckpt_pos,
    output logic [$clog2(N_CKPT)-1:0]    ckpt_id,
    output logic                         ckpt_full,
    input  logic                         ckpt_release,
    input  logic [$clog2(N_CKPT)-1:0]    release_id,
    input  logic                         recover,
    input  logic [$clog2(N_CKPT)-1:0]    recover_id,
    input  logic                         flush
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(N_WAY) + 1;
    localparam int CK_W  = $clog2(N_CKPT);

    logic [PREG_W-1:0]            ring_reg [DEPTH];
    logic [PTR_W-1:0]             head_reg, tail_reg, free_num_reg;
    logic [PTR_W-1:0]             head_next, tail_next;
    fl_ckpt_t                     ckpt_reg [N_CKPT];
    logic [CNT_W-1:0]             grant_cnt, ret_cnt;
    logic [N_WAY-1:0][PREG_W-1:0] ret_tags;
    logic                         take_fire;
    logic [N_CKPT-1:0]            kill_mask;
    logic [PTR_W-1:0]             rec_dist;

    assign free_num = free_num_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_WAY; gi++) begin : g_alloc
            assign alloc_grant[gi] = !reset && !recover && !flush &&
                                     (CNT_W'(gi) < alloc_num) && (PTR_W'(gi) < free_num_reg);
            assign alloc_tag[gi]   = ring_reg[head_reg[IDX_W-1:0] + IDX_W'(gi)];
        end
    endgenerate

    // Grants form a prefix mask, so their popcount is the head advance.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_WAY; i++) grant_cnt = grant_cnt + CNT_W'(alloc_grant[i]);
    end

    free_list_ckpt_retire_compact #(
        .N_WAY  (N_WAY),
        .PREG_W (PREG_W)
    ) u_compact (
        .valid (retire_valid),
        .told  (retire_told),
        .tags  (ret_tags),
        .count (ret_cnt)
    );

    assign tail_next = tail_reg + PTR_W'(ret_cnt);

    // Lowest free checkpoint slot; full when every slot is live.
    always_comb begin
        ckpt_id   = '0;
        ckpt_full = 1'b1;
        for (int k = N_CKPT - 1; k >= 0; k--) begin
            if (!ckpt_reg[k].valid) begin
                ckpt_id   = CK_W'(k);
                ckpt_full = 1'b0;
            end
        end
    end

    assign take_fire = ckpt_take && !ckpt_full && !recover && !flush && !reset;

    // Checkpoints younger than the recovered one sit farther from tail.
    always_comb begin
        rec_dist = ring_dist(ckpt_reg[recover_id].ptr, tail_reg);
        for (int k = 0; k < N_CKPT; k++)
            kill_mask[k] = (CK_W'(k) == recover_id) ||
                           (ckpt_reg[k].valid && ring_dist(ckpt_reg[k].ptr, tail_reg) > rec_dist);
    end

    // Next head: flush reopens the whole ring, recover rewinds, else allocate.
    always_comb begin
        if (flush)
            head_next = {~tail_next[PTR_W-1], tail_next[IDX_W-1:0]};
        else if (recover)
            head_next = ckpt_reg[recover_id].ptr;
        else
            head_next = head_reg + PTR_W'(grant_cnt);
    end

    // Pointer, ring and checkpoint state update.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg     <= '0;
            tail_reg     <= {1'b1, {IDX_W{1'b0}}};
            free_num_reg <= PTR_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) ring_reg[i] <= PREG_W'(FIRST_FREE + i);
            for (int k = 0; k < N_CKPT; k++) ckpt_reg[k] <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            free_num_reg <= tail_next - head_next;
            for (int j = 0; j < N_WAY; j++)
                if (CNT_W'(j) < ret_cnt)
                    ring_reg[tail_reg[IDX_W-1:0] + IDX_W'(j)] <= ret_tags[j];
            for (int k = 0; k < N_CKPT; k++) begin
                if (flush) begin
                    ckpt_reg[k].valid <= 1'b0;
                end else if (recover && kill_mask[k]) begin
                    ckpt_reg[k].valid <= 1'b0;
                end else if (take_fire && ckpt_id == CK_W'(k)) begin
                    ckpt_reg[k].valid <= 1'b1;
                    ckpt_reg[k].ptr   <= head_reg + PTR_W'(ckpt_pos);
                end else if (ckpt_release && release_id == CK_W'(k)) begin
                    ckpt_reg[k].valid <= 1'b0;
                end
            end
        end
    end

    a_alloc_num: assert property (@(posedge clock) disable iff (reset)
        alloc_num <= CNT_W'(N_WAY));
    a_take_full: assert property (@(posedge clock) disable iff (reset)
        !(ckpt_take && ckpt_full));
    a_ckpt_pos: assert property (@(posedge clock) disable iff (reset)
        take_fire |-> (ckpt_pos <= grant_cnt));

endmodule

// File: tb/tb_free_list_ckpt.sv
// Bench for free_list_ckpt: a table of allocation vectors, hand-written
// checkpoint/recover/flush sequences, then random traffic against a queue model.
module tb_free_list_ckpt;
    localparam int N_WAY = 2, DEPTH = 32, PREG_W = 6, N_CKPT = 4, FIRST_FREE = 32;

    logic                         clock = 1'b0;
    logic                         reset;
    logic [1:0]                   alloc_num;
    logic [N_WAY-1:0][PREG_W-1:0] alloc_tag;
    logic [N_WAY-1:0]             alloc_grant;
    logic [5:0]                   free_num;
    logic [N_WAY-1:0]             retire_valid;
    logic [N_WAY-1:0][PREG_W-1:0] retire_told;
    logic                         ckpt_take;
    logic [1:0]                   ckpt_pos;
    logic [1:0]                   ckpt_id;
    logic                         ckpt_full;
    logic                         ckpt_release;
    logic [1:0]                   release_id;
    logic                         recover;
    logic [1:0]                   recover_id;
    logic                         flush;

    always #5 clock = ~clock;

    free_list_ckpt #(
        .N_WAY(N_WAY), .DEPTH(DEPTH), .PREG_W(PREG_W), .N_CKPT(N_CKPT), .FIRST_FREE(FIRST_FREE)
    ) dut (
        .clock(clock), .reset(reset), .alloc_num(alloc_num), .alloc_tag(alloc_tag),
        .alloc_grant(alloc_grant), .free_num(free_num), .retire_valid(retire_valid),
        .retire_told(retire_told), .ckpt_take(ckpt_take), .ckpt_pos(ckpt_pos),
        .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
        .release_id(release_id), .recover(recover), .recover_id(recover_id), .flush(flush)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        alloc_num = 0; retire_valid = '0; retire_told = '0; ckpt_take = 0; ckpt_pos = 0;
        ckpt_release = 0; release_id = 0; recover = 0; recover_id = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] an;
        logic [1:0] g;
        int         t0;
        int         t1;
        logic       tag_care;
        int         fn;
    } vec_t;
    vec_t vecs[17];

    // Queue model state
    typedef struct { int p; int seq; } rob_t;
    int   free_q[$];
    int   arch_q[$];
    rob_t rob[$];
    int   ck_valid[N_CKPT];
    int   ck_b[N_CKPT];
    int   alloc_seq;

    initial begin
        for (int c = 0; c < 16; c++) vecs[c] = '{2'd2, 2'b11, 32 + 2*c, 33 + 2*c, 1'b1, 32 - 2*c};
        vecs[16] = '{2'd2, 2'b00, 0, 0, 1'b0, 0};

        // Reset state, with alloc_num held high during reset
        idle();
        reset = 1'b1;
        alloc_num = 2;
        #1 chk("rst_grant", alloc_grant, 0);
        @(negedge clock);
        @(negedge clock);
        chk("rst_free_num", free_num, 32);
        chk("rst_ckpt_full", ckpt_full, 0);
        chk("rst_ckpt_id", ckpt_id, 0);
        reset = 1'b0;

        // Drain the list two tags per cycle
        for (int c = 0; c < 17; c++) begin
            alloc_num = vecs[c].an;
            #1;
            chk($sformatf("vec%0d_grant", c), alloc_grant, vecs[c].g);
            chk($sformatf("vec%0d_free", c), free_num, vecs[c].fn);
            if (vecs[c].tag_care) begin
                chk($sformatf("vec%0d_tag0", c), alloc_tag[0], vecs[c].t0);
                chk($sformatf("vec%0d_tag1", c), alloc_tag[1], vecs[c].t1);
            end
            $display("vec %0d an=%0d grant=%b tags=%0d,%0d free=%0d", c, alloc_num, alloc_grant,
                     alloc_tag[0], alloc_tag[1], free_num);
            @(negedge clock);
        end

        // One free entry, two requested
        idle();
        retire_valid = 2'b01; retire_told[0] = 6'd40;
        #1 chk("B_free0", free_num, 0);
        @(negedge clock);
        idle();
        alloc_num = 2;
        #1;
        chk("B_grant", alloc_grant, 1);
        chk("B_tag0", alloc_tag[0], 40);
        chk("B_free1", free_num, 1);
        $display("seqB grant=%b tag0=%0d free=%0d", alloc_grant, alloc_tag[0], free_num);
        @(negedge clock);
        idle();
        #1 chk("B_free_after", free_num, 0);

        // Checkpoint mid-pair, recover after more allocation
        do_reset();
        alloc_num = 2; #1; @(negedge clock);
        alloc_num = 2; #1; @(negedge clock);
        alloc_num = 2; ckpt_take = 1; ckpt_pos = 1;
        #1;
        chk("C_take_id", ckpt_id, 0);
        chk("C_take_grant", alloc_grant, 3);
        @(negedge clock);
        idle();
        for (int c = 0; c < 3; c++) begin alloc_num = 2; #1; @(negedge clock); end
        idle();
        alloc_num = 2; recover = 1; recover_id = 0;
        #1;
        chk("C_rec_grant", alloc_grant, 0);
        chk("C_free_pre", free_num, 20);
        @(negedge clock);
        idle();
        #1;
        chk("C_free_post", free_num, 27);
        chk("C_tag0_post", alloc_tag[0], 37);
        chk("C_ckpt_id", ckpt_id, 0);
        chk("C_ckpt_full", ckpt_full, 0);
        $display("seqC free=%0d tag0=%0d ckpt_id=%0d", free_num, alloc_tag[0], ckpt_id);

        // Three checkpoints in age order, recover the middle one
        do_reset();
        for (int c = 0; c < 3; c++) begin
            alloc_num = 2; ckpt_take = 1; ckpt_pos = 2'(c);
            #1 chk($sformatf("D_take%0d_id", c), ckpt_id, c);
            @(negedge clock);
        end
        idle();
        #1 chk("D_id_after3", ckpt_id, 3);
        @(negedge clock);
        recover = 1; recover_id = 1;
        #1; @(negedge clock);
        idle();
        ckpt_take = 1;
        #1;
        chk("D_free_post", free_num, 29);
        chk("D_tag0_post", alloc_tag[0], 35);
        chk("D_id_first_free", ckpt_id, 1);
        chk("D_full_post", ckpt_full, 0);
        @(negedge clock);
        #1 chk("D_id_next", ckpt_id, 2);
        @(negedge clock);
        #1 chk("D_id_last", ckpt_id, 3);
        @(negedge clock);
        idle();
        #1 chk("D_full_end", ckpt_full, 1);
        $display("seqD full=%0d", ckpt_full);

        // Flush while retiring told {40, 0}
        do_reset();
        alloc_num = 2; ckpt_take = 1; ckpt_pos = 0;
        #1; @(negedge clock);
        idle();
        alloc_num = 2; #1; @(negedge clock);
        idle();
        alloc_num = 2; flush = 1; retire_valid = 2'b11; retire_told[0] = 6'd40; retire_told[1] = 6'd0;
        #1 chk("E_flush_grant", alloc_grant, 0);
        @(negedge clock);
        idle();
        #1;
        chk("E_free", free_num, 32);
        chk("E_ckpt_id", ckpt_id, 0);
        chk("E_ckpt_full", ckpt_full, 0);
        chk("E_tag0", alloc_tag[0], 33);
        chk("E_tag1", alloc_tag[1], 34);
        for (int c = 0; c < 15; c++) begin alloc_num = 2; #1; @(negedge clock); end
        idle();
        #1;
        chk("E_free_tail", free_num, 2);
        chk("E_tag_63", alloc_tag[0], 63);
        chk("E_tag_40", alloc_tag[1], 40);
        $display("seqE tags=%0d,%0d free=%0d", alloc_tag[0], alloc_tag[1], free_num);

        // Random traffic against the queue model
        free_q.delete(); arch_q.delete(); rob.delete();
        for (int t = 32; t < 64; t++) free_q.push_back(t);
        for (int t = 1; t < 32; t++) arch_q.push_back(t);
        for (int k = 0; k < N_CKPT; k++) begin ck_valid[k] = 0; ck_b[k] = 0; end
        alloc_seq = 0;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            int an, sz, g, live, full, eid, minb, elig, used, b, maxp, pos;
            int do_fl, do_rc, rcid, do_tk, do_rl, rlid, nret, tk_eff;
            int ret_t[N_WAY];
            idle();
            an = int'($urandom_range(0, 2));
            sz = free_q.size();
            live = 0; full = 1; eid = -1; minb = 32'h7fffffff;
            for (int k = 0; k < N_CKPT; k++) begin
                if (ck_valid[k] != 0) begin
                    live++;
                    if (ck_b[k] < minb) minb = ck_b[k];
                end else begin
                    full = 0;
                    if (eid < 0) eid = k;
                end
            end
            do_fl = ($urandom_range(0, 99) < 3) ? 1 : 0;
            do_rc = (do_fl == 0 && live > 0 && $urandom_range(0, 99) < 10) ? 1 : 0;
            rcid = 0;
            if (do_rc != 0) begin
                do rcid = int'($urandom_range(0, N_CKPT - 1)); while (ck_valid[rcid] == 0);
            end
            g = (do_fl != 0 || do_rc != 0) ? 0 : ((an < sz) ? an : sz);
            do_tk = (full == 0 && sz > 0 && $urandom_range(0, 99) < 35) ? 1 : 0;
            maxp = (g == sz) ? g - 1 : g;
            pos = (do_tk != 0 && maxp > 0) ? int'($urandom_range(0, maxp)) : 0;
            tk_eff = (do_tk != 0 && do_fl == 0 && do_rc == 0) ? 1 : 0;
            do_rl = (live > 0 && $urandom_range(0, 99) < 25) ? 1 : 0;
            rlid = 0;
            if (do_rl != 0) begin
                do rlid = int'($urandom_range(0, N_CKPT - 1)); while (ck_valid[rlid] == 0);
            end
            elig = 0;
            while (elig < rob.size() && elig < N_WAY && rob[elig].seq < minb) elig++;
            used = 0; nret = 0;
            for (int i = 0; i < N_WAY; i++) begin
                int kind;
                kind = int'($urandom_range(0, 3));
                if (kind == 1) begin
                    retire_valid[i] = 1'b1; retire_told[i] = '0;
                end else if (kind >= 2 && used < elig) begin
                    rob_t e;
                    int told;
                    e = rob.pop_front();
                    told = arch_q.pop_front();
                    arch_q.push_back(e.p);
                    retire_valid[i] = 1'b1; retire_told[i] = PREG_W'(told);
                    ret_t[nret] = told; nret++; used++;
                end
            end
            alloc_num = 2'(an); flush = 1'(do_fl); recover = 1'(do_rc); recover_id = 2'(rcid);
            ckpt_take = 1'(do_tk); ckpt_pos = 2'(pos); ckpt_release = 1'(do_rl); release_id = 2'(rlid);
            #1;
            chk("R_free_num", free_num, sz);
            chk("R_grant", alloc_grant, (1 << g) - 1);
            for (int i = 0; i < N_WAY; i++)
                if (i < sz) chk($sformatf("R_tag%0d", i), alloc_tag[i], free_q[i]);
            chk("R_ckpt_full", ckpt_full, full);
            if (full == 0) chk("R_ckpt_id", ckpt_id, eid);
            $display("rnd %0d an=%0d g=%0d free=%0d ret=%0d take=%0d rel=%0d rec=%0d fl=%0d",
                     cyc, an, g, sz, nret, tk_eff, do_rl, do_rc, do_fl);
            // Apply the cycle to the model
            b = alloc_seq + pos;
            for (int i = 0; i < g; i++) begin
                rob.push_back('{free_q.pop_front(), alloc_seq});
                alloc_seq++;
            end
            for (int i = 0; i < nret; i++) free_q.push_back(ret_t[i]);
            if (do_rl != 0) ck_valid[rlid] = 0;
            if (tk_eff != 0) begin ck_valid[eid] = 1; ck_b[eid] = b; end
            if (do_fl != 0) begin
                while (rob.size() > 0) free_q.push_front(rob.pop_back().p);
                for (int k = 0; k < N_CKPT; k++) ck_valid[k] = 0;
            end else if (do_rc != 0) begin
                int brid;
                brid = ck_b[rcid];
                while (rob.size() > 0 && rob[rob.size() - 1].seq >= brid)
                    free_q.push_front(rob.pop_back().p);
                alloc_seq = brid;
                for (int k = 0; k < N_CKPT; k++)
                    if (k == rcid || (ck_valid[k] != 0 && ck_b[k] > brid)) ck_valid[k] = 0;
            end
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
